// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM encoding, instruction word and opcode field.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_FULL = 2'd2
    } fetch_st_e;

    typedef logic [15:0] instr_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] OPC_LOAD  = 4'h0;
    localparam logic [3:0] OPC_STORE = 4'h1;
    localparam logic [3:0] OPC_ADD   = 4'h2;
    localparam logic [3:0] OPC_LDI   = 4'h3;
    localparam logic [3:0] OPC_SUB   = 4'h4;
    localparam logic [3:0] OPC_JMPZ  = 4'h5;

    function automatic logic [3:0] opcode(input instr_t w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: clear beats increment, wraps naturally at 2^W.
module pc_counter
    import instr_fetch_unit_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      pc_q <= '0;
        else if (clr_i) pc_q <= '0;
        else if (inc_i) pc_q <= pc_q + W'(1);
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, prefetches the word at PC from a fixed-latency
// pipelined instruction memory and flags stalls through IRValid.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH     = 7,
    parameter int IMEM_LATENCY = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                PCClr,
    input  logic                PCUp,
    input  logic                IRLd,
    output logic [PC_WIDTH-1:0] IMemAddr,
    output logic                IMemRdEn,
    input  instr_t              IMemRdData,
    output instr_t              Instruction,
    output logic [PC_WIDTH-1:0] PCOut,
    output logic                IRValid,
    output logic                FetchBusy
);

    localparam int CNT_W = 3;

    fetch_st_e          st_q;
    logic [CNT_W-1:0]   cnt_q;
    instr_t             ir_q;
    instr_t             pf_q;
    logic               pend_q;
    logic               adv_q;
    logic               irv_q;
    logic [PC_WIDTH-1:0] pc;
    logic               pend_eff;
    logic               adv_eff;

    pc_counter #(.W(PC_WIDTH)) u_pc (
        .clk_i (Clk),
        .rst_i (Rst),
        .clr_i (PCClr),
        .inc_i (PCUp & ~PCClr),
        .pc_o  (pc)
    );

    // An IRLd this cycle already claims the in-flight read, so fold it in.
    assign pend_eff = pend_q | IRLd;
    assign adv_eff  = adv_q | PCUp;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            st_q   <= FS_REQ;
            cnt_q  <= '0;
            ir_q   <= '0;
            pf_q   <= '0;
            pend_q <= 1'b0;
            adv_q  <= 1'b0;
            irv_q  <= 1'b0;
        end else if (PCClr) begin
            st_q   <= FS_REQ;
            pend_q <= 1'b0;
            adv_q  <= 1'b0;
            irv_q  <= 1'b0;
        end else begin
            case (st_q)
                FS_REQ: begin
                    cnt_q <= CNT_W'(IMEM_LATENCY);
                    if (IRLd) begin
                        pend_q <= 1'b1;
                        irv_q  <= 1'b0;
                    end
                    if (pend_eff) begin
                        adv_q <= adv_eff;
                        st_q  <= FS_WAIT;
                    end else if (PCUp) begin
                        st_q  <= FS_REQ;
                    end else begin
                        st_q  <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (IRLd) begin
                        pend_q <= 1'b1;
                        irv_q  <= 1'b0;
                    end
                    if (pend_eff && PCUp) adv_q <= 1'b1;
                    if (!pend_eff && PCUp) begin
                        // Abandon the read; the counter restart keeps its data out.
                        st_q <= FS_REQ;
                    end else if (cnt_q == CNT_W'(1)) begin
                        if (pend_eff) begin
                            ir_q   <= IMemRdData;
                            irv_q  <= 1'b1;
                            pend_q <= 1'b0;
                            adv_q  <= 1'b0;
                        end
                        if (pend_eff && adv_eff) begin
                            st_q <= FS_REQ;
                        end else begin
                            pf_q <= IMemRdData;
                            st_q <= FS_FULL;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FS_FULL: begin
                    if (IRLd) begin
                        ir_q  <= pf_q;
                        irv_q <= 1'b1;
                    end
                    if (PCUp) st_q <= FS_REQ;
                end
                default: st_q <= FS_REQ;
            endcase
        end
    end

    assign IMemAddr    = pc;
    assign IMemRdEn    = (st_q == FS_REQ) & ~Rst;
    assign FetchBusy   = (st_q != FS_FULL);
    assign Instruction = ir_q;
    assign PCOut       = pc;
    assign IRValid     = irv_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the controller state machine. It owns the program counter and the instruction register, and prefetches the word at the current PC from a pipelined, fixed-latency instruction memory. It executes the controller's PCClr/PCUp/IRLd commands and presents the 16-bit Instruction that the controller decodes. Memory latency is hidden behind the decode/execute cycles; when it cannot be hidden, the stall is flagged with IRValid.

## Interface
- PC_WIDTH, 7: program counter width; instruction memory depth is 2^PC_WIDTH words.
- IMEM_LATENCY, 1: cycles from IMemRdEn to valid IMemRdData; legal range 1..4.

- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  reset; one clock, reset is asynchronous and active-high.
- PCClr  in  1  clear PC to 0 and abort any prefetch.
- PCUp  in  1  increment PC.
- IRLd  in  1  load the IR with the word at the current PC.
- IMemAddr  out  PC_WIDTH  instruction memory read address.
- IMemRdEn  out  1  one-cycle read strobe.
- IMemRdData  in  16  read data, valid exactly IMEM_LATENCY cycles after the strobe.
- Instruction  out  16  IR contents, feeds the controller's instruction input.
- PCOut  out  PC_WIDTH  current PC.
- IRValid  out  1  IR holds the word requested by the last IRLd.
- FetchBusy  out  1  prefetch buffer not valid (read in flight or pending).

## Operation
- Internal state: PC, IR, 16-bit prefetch register PF, latency counter, IRPending flag.
- FSM states: REQ, WAIT, FULL.
  - REQ: IMemRdEn=1, IMemAddr=PC, counter loaded with IMEM_LATENCY, go to WAIT.
  - WAIT: counter decrements each cycle. In the cycle it reaches 0, IMemRdData is captured. Capture goes to IR if IRPending (then IRPending=0, IRValid=1, next state REQ when PC has advanced past the captured address, else FULL), otherwise to PF (next state FULL).
  - FULL: PF holds the word at PC; hold until a command arrives.
- Commands are evaluated every cycle, with priority PCClr > PCUp/IRLd.
  - PCClr: PC=0, IRPending=0, IRValid=0, state=REQ. IRLd and PCUp are ignored that cycle. IR value is unchanged.
  - IRLd in FULL: IR=PF, IRValid=1.
  - IRLd in REQ/WAIT: IRValid=0, IRPending=1. The in-flight read (for the pre-increment PC) completes into IR.
  - PCUp: PC=PC+1 mod 2^PC_WIDTH, with wrap 2^PC_WIDTH-1 -> 0. PF is invalidated.
    - If no capture is pending, state=REQ for the new PC.
    - If IRPending, the in-flight read finishes first, then REQ.
  - PCUp and IRLd together (normal FETCH): IR gets the word at the old PC, PC advances.
- Aborted reads are never cancelled at the memory. Because latency is fixed and the counter restarts on REQ, stale data is never captured.
- FetchBusy = (state != FULL). IMemAddr holds PC in all states.
- Reset values: PC=0, IR=16'h0000, PF=0, IRPending=0, IRValid=0, IMemRdEn=0, FetchBusy=1. The first state after reset release is REQ.
- Reset asserted mid-read behaves identically to power-up. Any data returning later is ignored.

## Timing
- A REQ in cycle T implies the PF/IR capture edge at the end of cycle T+IMEM_LATENCY. FULL or IRValid is visible in cycle T+IMEM_LATENCY+1.
- Refetch after PCUp takes IMEM_LATENCY+1 cycles.
- With IMEM_LATENCY=1 and the controller's minimum of 2 cycles between FETCHes, every FETCH after the first finds FULL, giving zero stall.
- First FETCH after PCClr stalls: IRValid rises IMEM_LATENCY+1 cycles after the FETCH cycle.
- Instruction, PCOut and IRValid are registered. IMemRdEn and FetchBusy decode from the state register.

## Structure
- The shared package holds the fetch FSM enum (REQ/WAIT/FULL), the 16-bit instruction word type, and the opcode field constants (bits 15:12) shared with the controller.
- One natural sub-module is `pc_counter`: a PC_WIDTH register with clear, increment, wrap and async reset.

## Test plan
- Reset release, IMEM_LATENCY=1, memory[0]=16'h2123 -> IMemRdEn pulse at addr 0 in cycle 0, FetchBusy=0 from cycle 2, IRValid=0, Instruction=16'h0000.
- FULL at PC=0 with memory[0]=16'h2123, memory[1]=16'h3456, then PCUp+IRLd -> Instruction=16'h2123, IRValid=1, PCOut=1; the next read at addr 1 fills PF with 16'h3456 two cycles later.
- PCClr immediately followed by PCUp+IRLd (INIT->FETCH), IMEM_LATENCY=3 -> IRValid=0 for 4 cycles, then Instruction=memory[0] and PCOut=1, and only after that does a REQ for addr 1 issue.
- PC=7'h7F, FULL, then PCUp+IRLd -> Instruction=memory[127], PCOut=0, next IMemAddr=0.
- PCUp during WAIT with no IRLd, then PCClr during WAIT -> no capture of either stale word; PF is finally memory[0], with REQ timing from the PCClr cycle.
- Rst asserted asynchronously mid-WAIT with IRValid=1 -> all outputs return to reset values immediately, without waiting for a clock edge.
